systolic_seq: RTL and testbench

Sequencer for the 4x4 weight-stationary systolic array. Holds the operand matrix and weight matrix in local register files, clears the array, streams operand columns into `in_up` with the diagonal skew the array requires, waits for the pipeline to drain, then snapshots `out_down`/`out_right` into result registers and signals completion. Sits between the host/load logic and the array top, replacing hand-driven stimulus.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/skew_feeder.sv | 21 ++
 rtl/systolic_seq.sv | 124 ++++++++++++
 tb/tb_systolic_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array sequencer.
package systolic_pkg;

  localparam int unsigned DefN     = 4;
  localparam int unsigned DefWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StDone
  } seq_state_t;

  typedef logic signed [DefWidth-1:0] row_t [0:DefN-1];

endpackage

// File: rtl/skew_feeder.sv
// Diagonal skew of a square matrix: lane j carries element [t-j][j] at beat t, else zero.
module skew_feeder #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TW    = 3
) (
  input  logic signed [WIDTH-1:0] a    [0:N-1][0:N-1],
  input  logic        [TW-1:0]    t,
  output logic signed [WIDTH-1:0] feed [0:N-1]
);

  always_comb begin
    for (int j = 0; j < N; j++) begin
      feed[j] = '0;
      for (int i = 0; i < N; i++) begin
        if (int'(t) == i + j) feed[j] = a[i][j];
      end
    end
  end

endmodule

// File: rtl/systolic_seq.sv
// Sequencer for the NxN weight-stationary systolic array: holds A and W, clears the array,
// feeds skewed operand columns, waits for drain, then captures the array outputs.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int unsigned N            = DefN,
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(N)-1:0]     wr_row,
  input  logic signed [WIDTH-1:0]  wr_data   [0:N-1],
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     arr_rst,
  output logic signed [WIDTH-1:0]  in_up     [0:N-1],
  output logic signed [WIDTH-1:0]  in_left   [0:N-1],
  output logic signed [WIDTH-1:0]  weights   [0:N-1][0:N-1],
  input  logic signed [WIDTH-1:0]  out_down  [0:N-1],
  input  logic signed [WIDTH-1:0]  out_right [0:N-1],
  output logic signed [WIDTH-1:0]  res_down  [0:N-1],
  output logic signed [WIDTH-1:0]  res_right [0:N-1]
);

  localparam int unsigned TW        = $clog2(2 * N);
  localparam logic [TW-1:0] TLast   = TW'(2 * N - 2);
  localparam logic [3:0] DrainLast  = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

  seq_state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [3:0]    dc_q, dc_d;

  logic signed [WIDTH-1:0] a_q         [0:N-1][0:N-1];
  logic signed [WIDTH-1:0] w_q         [0:N-1][0:N-1];
  logic signed [WIDTH-1:0] res_down_q  [0:N-1];
  logic signed [WIDTH-1:0] res_right_q [0:N-1];
  logic signed [WIDTH-1:0] skew        [0:N-1];

  skew_feeder #(
    .N    (N),
    .WIDTH(WIDTH),
    .TW   (TW)
  ) u_skew (
    .a   (a_q),
    .t   (t_q),
    .feed(skew)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    dc_d    = dc_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StClear;
      StClear: begin
        state_d = StFeed;
        t_d     = '0;
      end
      StFeed: begin
        if (t_q == TLast) begin
          t_d     = '0;
          dc_d    = '0;
          state_d = (DRAIN_CYCLES == 0) ? StDone : StDrain;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      StDrain: begin
        if (dc_q == DrainLast) begin
          dc_d    = '0;
          state_d = StDone;
        end else begin
          dc_d = dc_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      t_q         <= '0;
      dc_q        <= '0;
      a_q         <= '{default: '0};
      w_q         <= '{default: '0};
      res_down_q  <= '{default: '0};
      res_right_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      dc_q    <= dc_d;
      // Matrices are frozen outside IDLE so a run always sees a consistent A and W.
      if (wr_en && state_q == StIdle) begin
        if (wr_sel) w_q[wr_row] <= wr_data;
        else        a_q[wr_row] <= wr_data;
      end
      if (state_d == StDone && state_q != StDone) begin
        res_down_q  <= out_down;
        res_right_q <= out_right;
      end
    end
  end

  always_comb begin
    busy    = (state_q == StClear) || (state_q == StFeed) || (state_q == StDrain);
    done    = (state_q == StDone);
    arr_rst = (state_q == StClear);
    for (int j = 0; j < N; j++) begin
      in_up[j]   = (state_q == StFeed) ? skew[j] : '0;
      in_left[j] = '0;
    end
  end

  assign weights   = w_q;
  assign res_down  = res_down_q;
  assign res_right = res_right_q;

endmodule

// File: tb/tb_systolic_seq.sv
// Randomised self-checking bench for systolic_seq against a matrix-level reference model.
module tb_systolic_seq;
  import systolic_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [1:0] wr_row = '0;
  row_t       wr_data;
  logic       start = 1'b0;
  row_t       out_down, out_right;

  logic busy, done, arr_rst;
  row_t in_up, in_left, res_down, res_right;
  logic signed [W-1:0] weights [0:N-1][0:N-1];

  logic busy0, done0, arr_rst0;
  row_t in_up0, in_left0, res_down0, res_right0;
  logic signed [W-1:0] weights0 [0:N-1][0:N-1];

  systolic_seq #(.N(N), .WIDTH(W), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .arr_rst(arr_rst),
    .in_up(in_up), .in_left(in_left), .weights(weights), .out_down(out_down),
    .out_right(out_right), .res_down(res_down), .res_right(res_right)
  );

  systolic_seq #(.N(N), .WIDTH(W), .DRAIN_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_data(wr_data), .start(start), .busy(busy0), .done(done0), .arr_rst(arr_rst0),
    .in_up(in_up0), .in_left(in_left0), .weights(weights0), .out_down(out_down),
    .out_right(out_right), .res_down(res_down0), .res_right(res_right0)
  );

  // Reference state: the matrices as the host believes they were loaded.
  logic signed [W-1:0] am [0:N-1][0:N-1];
  logic signed [W-1:0] wm [0:N-1][0:N-1];
  row_t cap_d, cap_r;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic signed [W-1:0] exp_up(int t, int j);
    int i;
    i = t - j;
    if (t >= 0 && t <= 2 * N - 2 && i >= 0 && i < N) return am[i][j];
    return '0;
  endfunction

  task automatic write_row(input bit sel, input int row, input row_t d);
    @(negedge clk);
    wr_en  = 1'b1;
    wr_sel = sel;
    wr_row = 2'(row);
    wr_data = d;
    for (int j = 0; j < N; j++) begin
      if (sel) wm[row][j] = d[j];
      else     am[row][j] = d[j];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_fixed();
    row_t r;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) r[j] = 16'(i * N + j + 1);
      write_row(1'b0, i, r);
      for (int j = 0; j < N; j++) r[j] = 16'(i + j + 1);
      write_row(1'b1, i, r);
    end
  endtask

  task automatic load_random();
    row_t r;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) r[j] = 16'($urandom);
      write_row(1'b0, i, r);
      for (int j = 0; j < N; j++) r[j] = 16'($urandom);
      write_row(1'b1, i, r);
    end
  endtask

  task automatic drive_outs(input bit capture);
    for (int j = 0; j < N; j++) begin
      out_down[j]  = capture ? cap_d[j] : 16'($urandom);
      out_right[j] = capture ? cap_r[j] : 16'($urandom);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, arr_rst} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, arr_rst});
    end
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (in_up[j] !== 0 || in_left[j] !== 0 || res_down[j] !== 0 || res_right[j] !== 0) begin
        n_fail++; $display("FAIL reset_data[%0d]: got %0d/%0d/%0d/%0d expected 0", j, in_up[j],
                            in_left[j], res_down[j], res_right[j]);
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (weights[i][j] !== 0) begin
          n_fail++; $display("FAIL reset_w[%0d][%0d]: got %0d expected 0", i, j, weights[i][j]);
        end
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Full runs: the test-plan matrices first, then random matrices and capture values.
  task automatic test_feed();
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        load_fixed();
        cap_d = '{16'sd7, 16'sd8, 16'sd9, 16'sd10};
        cap_r = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
      end else begin
        load_random();
        for (int j = 0; j < N; j++) begin
          cap_d[j] = 16'($urandom);
          cap_r[j] = 16'($urandom);
        end
      end
      @(negedge clk);
      start = 1'b1;
      drive_outs(1'b0);
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        drive_outs(c == 12);
        n_checks++;
        if ({arr_rst, busy, done} !== {c == 1, c >= 1 && c <= 12, c == 13}) begin
          n_fail++; $display("FAIL feed_ctrl r%0d c%0d: got %b expected %b", r, c,
                              {arr_rst, busy, done}, {c == 1, c >= 1 && c <= 12, c == 13});
        end
        for (int j = 0; j < N; j++) begin
          n_checks++;
          if (in_up[j] !== exp_up(c - 2, j) || in_left[j] !== 0) begin
            n_fail++; $display("FAIL feed_in_up r%0d c%0d lane%0d: got %0d expected %0d", r, c, j,
                                in_up[j], exp_up(c - 2, j));
          end
          for (int i = 0; i < N; i++) begin
            n_checks++;
            if (weights[i][j] !== wm[i][j]) begin
              n_fail++; $display("FAIL feed_w r%0d [%0d][%0d]: got %0d expected %0d", r, i, j,
                                  weights[i][j], wm[i][j]);
            end
          end
          if (c >= 13) begin
            n_checks++;
            if (res_down[j] !== cap_d[j] || res_right[j] !== cap_r[j]) begin
              n_fail++; $display("FAIL capture r%0d c%0d lane%0d: got %0d/%0d expected %0d/%0d",
                                  r, c, j, res_down[j], res_right[j], cap_d[j], cap_r[j]);
            end
          end
        end
      end
    end
  endtask

  // Writes during a run must be dropped; a write coinciding with start must land.
  task automatic test_wr_ignored();
    row_t r99;
    load_fixed();
    r99 = '{16'sd99, 16'sd99, 16'sd99, 16'sd99};
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      start = 1'b1;
      if (r == 2) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0;
        for (int j = 0; j < N; j++) begin
          wr_data[j] = 16'($urandom);
          am[0][j] = wr_data[j];
        end
      end
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        wr_en = 1'b0;
        if (r == 0 && (c == 4 || c == 6)) begin
          wr_en = 1'b1; wr_sel = (c == 6); wr_row = (c == 6) ? 2'd2 : 2'd0; wr_data = r99;
        end
        for (int j = 0; j < N; j++) begin
          n_checks++;
          if (in_up[j] !== exp_up(c - 2, j)) begin
            n_fail++; $display("FAIL wr_ignored r%0d c%0d lane%0d: got %0d expected %0d", r, c, j,
                                in_up[j], exp_up(c - 2, j));
          end
        end
      end
      for (int j = 0; j < N; j++) begin
        n_checks++;
        if (weights[2][j] !== wm[2][j]) begin
          n_fail++; $display("FAIL wr_ignored_w lane%0d: got %0d expected %0d", j, weights[2][j],
                              wm[2][j]);
        end
      end
    end
  endtask

  task automatic test_start_held();
    int n_done, first, second, prev;
    n_done = 0; first = -1; second = -1; prev = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first < 0) first = c; else if (second < 0) second = c;
        n_checks++;
        if (prev == 1) begin
          n_fail++; $display("FAIL held_width c%0d: got 2-cycle done expected 1", c);
        end
      end
      prev = int'(done);
    end
    start = 1'b0;
    n_checks++;
    if (n_done !== 2 || first !== 13 || second - first !== 14) begin
      n_fail++; $display("FAIL held_period: got %0d pulses at %0d,%0d expected 2 at 13,27",
                          n_done, first, second);
    end
    for (int c = 0; c <= 30; c++) begin
      if (!busy && !done && !busy0 && !done0) break;
      n_checks++;
      if (c == 30) begin
        n_fail++; $display("FAIL held_settle: got busy after 30 cycles expected idle");
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    load_fixed();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (in_up[3] !== exp_up(3, 3)) begin
      n_fail++; $display("FAIL mid_pre lane3: got %0d expected %0d", in_up[3], exp_up(3, 3));
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, arr_rst} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset_ctrl: got %b expected 000", {busy, done, arr_rst});
    end
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (in_up[j] !== 0 || res_down[j] !== 0 || res_right[j] !== 0 || weights[j][j] !== 0) begin
        n_fail++; $display("FAIL mid_reset_data lane%0d: got %0d/%0d/%0d/%0d expected 0", j,
                            in_up[j], res_down[j], res_right[j], weights[j][j]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    am = '{default: '0};
    wm = '{default: '0};
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (done !== (c == 13)) begin
        n_fail++; $display("FAIL mid_rerun_done c%0d: got %b expected %b", c, done, c == 13);
      end
      for (int j = 0; j < N; j++) begin
        n_checks++;
        if (in_up[j] !== exp_up(c - 2, j) || weights[0][j] !== 0) begin
          n_fail++; $display("FAIL mid_rerun c%0d lane%0d: got %0d/%0d expected 0", c, j,
                              in_up[j], weights[0][j]);
        end
      end
    end
  endtask

  task automatic test_drain0();
    load_random();
    for (int j = 0; j < N; j++) begin
      cap_d[j] = 16'($urandom);
      cap_r[j] = 16'($urandom);
    end
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      drive_outs(c == 8);
      n_checks++;
      if ({busy0, done0} !== {c <= 8, c == 9}) begin
        n_fail++; $display("FAIL drain0_ctrl c%0d: got %b expected %b", c, {busy0, done0},
                            {c <= 8, c == 9});
      end
      for (int j = 0; j < N; j++) begin
        n_checks++;
        if (in_up0[j] !== exp_up(c - 2, j)) begin
          n_fail++; $display("FAIL drain0_in_up c%0d lane%0d: got %0d expected %0d", c, j,
                              in_up0[j], exp_up(c - 2, j));
        end
        if (c >= 9) begin
          n_checks++;
          if (res_down0[j] !== cap_d[j] || res_right0[j] !== cap_r[j]) begin
            n_fail++; $display("FAIL drain0_capture c%0d lane%0d: got %0d/%0d expected %0d/%0d",
                                c, j, res_down0[j], res_right0[j], cap_d[j], cap_r[j]);
          end
        end
      end
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    wr_data   = '{default: '0};
    out_down  = '{default: '0};
    out_right = '{default: '0};
    am = '{default: '0};
    wm = '{default: '0};
    test_reset();
    test_feed();
    test_wr_ignored();
    test_start_held();
    test_reset_mid();
    test_drain0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
